// File: rtl/stream_in_sample_packer_if.sv
// Sample-in / word-out bus for the FX3 stream-IN packer.
// master drives samples and pops; slave is the packer itself.
`timescale 1ns/1ps
interface stream_in_sample_packer_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  sample_valid;
    logic [15:0]           sample_data;
    logic                  sample_sync;
    logic                  rd_en;
    logic [31:0]           rd_data;
    logic                  rd_last;
    logic                  empty;
    logic                  ready_burst;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  clear_ovf;

    modport master (
        output sample_valid, sample_data, sample_sync, rd_en, clear_ovf,
        input  rd_data, rd_last, empty, ready_burst, level, overflow
    );

    modport slave (
        input  sample_valid, sample_data, sample_sync, rd_en, clear_ovf,
        output rd_data, rd_last, empty, ready_burst, level, overflow
    );
endinterface

// File: rtl/stream_in_sample_packer.sv
// Packs 16-bit ADC sample pairs into 32-bit words, tags packet-last words and buffers them in a FIFO.
// Optional build macro STREAM_IN_PACKER_TESTPAT_EN replaces ADC data with an incrementing word counter.
`timescale 1ns/1ps
module stream_in_sample_packer #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BURST_WORDS = 256,
    parameter int PKT_WORDS   = 4096
) (
    input  logic                      clk_100,
    input  logic                      reset_,
    stream_in_sample_packer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PW-1:0]       PKT_LAST  = PW'(PKT_WORDS - 1);
    localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_BURST = (DEPTH_LOG2 + 1)'(BURST_WORDS);

    typedef enum logic {
        LOW_EMPTY = 1'b0,
        HIGH_WAIT = 1'b1
    } pack_state_t;

    pack_state_t             r_state;
    logic [15:0]             r_low;
    logic                    r_word_sync;
    logic [PW-1:0]           r_pkt_cnt;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;
    logic [31:0]             r_rd_data;
    logic                    r_rd_last;
    logic                    r_overflow;
    logic [32:0]             r_mem [0:DEPTH-1];

    logic                    w_wr_req;
    logic [PW-1:0]           w_pkt_idx;
    logic                    w_wr_last;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_drop;
    logic [31:0]             w_wr_data;

    // A sync sample in HIGH_WAIT restarts the word instead of completing it.
    assign w_wr_req  = bus.sample_valid && (r_state == HIGH_WAIT) && !bus.sample_sync;
    assign w_pkt_idx = r_word_sync ? '0 : r_pkt_cnt;
    assign w_wr_last = (w_pkt_idx == PKT_LAST);
    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_pop     = bus.rd_en && !w_empty;
    assign w_accept  = w_wr_req && (!w_full || bus.rd_en);
    assign w_drop    = w_wr_req && !w_accept;

`ifdef STREAM_IN_PACKER_TESTPAT_EN
    logic [31:0] r_pat;

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_pat <= '0;
        end else if (w_accept) begin
            r_pat <= r_pat + 32'd1;
        end
    end

    assign w_wr_data = r_pat;
`else
    assign w_wr_data = {bus.sample_data, r_low};
`endif

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_state     <= LOW_EMPTY;
            r_low       <= '0;
            r_word_sync <= 1'b0;
        end else if (bus.sample_valid) begin
            case (r_state)
                LOW_EMPTY: begin
                    r_low       <= bus.sample_data;
                    r_word_sync <= bus.sample_sync;
                    r_state     <= HIGH_WAIT;
                end
                HIGH_WAIT: begin
                    if (bus.sample_sync) begin
                        r_low       <= bus.sample_data;
                        r_word_sync <= 1'b1;
                    end else begin
                        r_state <= LOW_EMPTY;
                    end
                end
                default: r_state <= LOW_EMPTY;
            endcase
        end
    end

    // A dropped word still honours a sync restart but does not advance the count.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_pkt_cnt <= '0;
        end else if (w_accept) begin
            r_pkt_cnt <= w_wr_last ? '0 : w_pkt_idx + 1'b1;
        end else if (w_drop) begin
            r_pkt_cnt <= w_pkt_idx;
        end
    end

    always_ff @(posedge clk_100) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {w_wr_last, w_wr_data};
        end
    end

    // At full with a simultaneous pop, the read sees the old head before the write lands.
    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
            r_rd_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr][31:0];
                r_rd_last <= r_mem[r_rd_ptr][32];
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.rd_data     = r_rd_data;
    assign bus.rd_last     = r_rd_last;
    assign bus.empty       = w_empty;
    assign bus.ready_burst = (r_level >= LVL_BURST);
    assign bus.level       = r_level;
    assign bus.overflow    = r_overflow;
endmodule

// File: doc/stream_in_sample_packer.md
# stream_in_sample_packer

Upstream feeder for the FX3 slave-FIFO stream-IN writer. Accepts 16-bit hydrophone ADC samples on clk_100 and packs sample pairs into 32-bit words. Buffers the words in an internal synchronous FIFO and presents a read-side interface to the writer. The writer pops words with single-cycle reads, uses the burst-ready flag to start an FX3 burst, and uses the per-word packet-last tag to drive pktend.

## Interface
Parameters:
- DEPTH_LOG2, 10, FIFO depth is 2^DEPTH_LOG2 words of 33 bits (32 data + last tag).
- BURST_WORDS, 256, ready_burst threshold in words; legal range 1..2^DEPTH_LOG2.
- PKT_WORDS, 4096, words per USB packet for last tagging; must be ≥ 2.

Ports:
- clk_100  in  1  system clock, 100 MHz, all logic on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- sample_valid  in  1  sample_data qualifies this cycle.
- sample_data  in  16  ADC sample.
- sample_sync  in  1  qualified by sample_valid; marks the first sample of a frame.
- rd_en  in  1  pop request from the writer.
- rd_data  out  32  popped word, registered.
- rd_last  out  1  popped word is the last word of a packet, registered.
- empty  out  1  FIFO holds 0 words.
- ready_burst  out  1  level ≥ BURST_WORDS.
- level  out  DEPTH_LOG2+1  current word count.
- overflow  out  1  sticky; a packed word was dropped.
- clear_ovf  in  1  synchronous clear of overflow.

## Operation
- Packer has two states:
  - LOW_EMPTY: a valid sample is latched as the low half; move to HIGH_WAIT.
  - HIGH_WAIT: a valid sample forms the word {sample_data, low_half}, issues a write, and returns to LOW_EMPTY.
- sample_sync with sample_valid in HIGH_WAIT: discard the pending low half, latch the new sample as the low half, stay in HIGH_WAIT.
- Packet counter pkt_cnt, range 0..PKT_WORDS-1:
  - The written word's last tag = (pkt_cnt == PKT_WORDS-1).
  - pkt_cnt increments on each accepted write and wraps to 0.
  - A sample_sync that starts a new word forces that word's pkt_cnt to 0. The preceding packet is then short and carries no last tag.
- Write acceptance:
  - Accepted if level < 2^DEPTH_LOG2, or if level == 2^DEPTH_LOG2 with rd_en in the same cycle (simultaneous pop and push).
  - Otherwise the word is dropped, overflow sets, and pkt_cnt does not advance.
- Read:
  - rd_en with empty=0 pops the head word.
  - rd_en with empty=1 is ignored; rd_data and rd_last hold.
- level: +1 on accepted write only, -1 on pop only, unchanged on simultaneous push and pop.
- Pointers are DEPTH_LOG2 bits and wrap naturally.
- overflow precedence: clear_ovf and a drop in the same cycle leave overflow=1 (set wins).

## Timing
- Reset values: rd_data=0, rd_last=0, empty=1, ready_burst=0, level=0, overflow=0, packer in LOW_EMPTY, pkt_cnt=0, pointers=0.
- Write latency: second sample at edge N writes the word at edge N. level, empty and ready_burst reflect it from cycle N+1; they are derived from registered state.
- Read latency: rd_en sampled at edge M. rd_data and rd_last are valid after edge M and hold until the next accepted pop.
- Reset mid-operation: the pending half and all buffered words are lost; outputs return to their reset values asynchronously.
- Throughput: 1 sample per cycle in, 1 word per cycle out sustained.

## Configuration
- STREAM_IN_PACKER_TESTPAT_EN defined:
  - sample_data is ignored.
  - Each written word is a 32-bit pattern counter, reset 0, incremented per accepted write.
  - Packing cadence (two sample_valid per word), sync, last tagging and overflow are unchanged.
  - FX3 host tools verify the data as a contiguous incrementing sequence.
- Not defined: words carry ADC data; no pattern counter logic is present.

## Test plan
- Reset, then samples 0x1111, 0x2222 on consecutive cycles -> next cycle empty=0, level=1. rd_en -> rd_data=0x22221111, rd_last=0.
- Samples A, sync+B, C (sync on B) -> single word {C,B}; A discarded; that word is the first of a new packet (pkt_cnt=0).
- PKT_WORDS=4, write 8 words, pop all -> rd_last=1 on words 4 and 8 only.
- DEPTH_LOG2=3, write 9 words with no reads -> level=8, overflow=1, ninth word absent. clear_ovf -> overflow=0. Write at full with rd_en held -> accepted, level stays 8, overflow stays 0.
- BURST_WORDS=4: ready_burst rises in the cycle after the 4th accepted write. One pop drops it in the following cycle. rd_en while empty -> rd_data unchanged.
- With STREAM_IN_PACKER_TESTPAT_EN, stream 2000 samples and pop continuously -> rd_data = 0, 1, 2, …, 999 with no gaps.
